// File: rtl/pcs_10g_pkg.sv
// Shared constants for the 10GBASE-R PCS transmit path: sync header codes,
// datapath widths and the gearbox sequence limit.
package pcs_10g_pkg;

    localparam int BLOCK_W = 64;
    localparam int HEAD_W  = 2;
    localparam int DATA_W  = 64;
    localparam int SEQ_W   = 6;

    localparam logic [1:0] SYNC_HEAD_DATA = 2'b01;
    localparam logic [1:0] SYNC_HEAD_CTRL = 2'b10;

    // 32 accepts of 66 bits leave exactly one 64-bit word of residue.
    localparam logic [5:0] GB_SEQ_MAX = 6'd32;

endpackage

// File: rtl/pcs_10g_tx_gearbox.sv
// 66b-to-64b transmit gearbox: 32 blocks in, 33 words out. Optional macro
// PCS_TX_GB_UNDERFLOW_CNT_EN adds a saturating underflow counter output.
module pcs_10g_tx_gearbox #(
    parameter int BLOCK_W = pcs_10g_pkg::BLOCK_W,
    parameter int HEAD_W  = pcs_10g_pkg::HEAD_W,
    parameter int DATA_W  = pcs_10g_pkg::DATA_W,
    parameter int SEQ_W   = pcs_10g_pkg::SEQ_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               head_v_i,
    input  logic [HEAD_W-1:0]  sync_head_i,
    input  logic [BLOCK_W-1:0] data_i,
    output logic               ready_o,
    output logic               valid_o,
    output logic [DATA_W-1:0]  data_o,
    output logic [SEQ_W-1:0]   seq_o
`ifdef PCS_TX_GB_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]        underflow_cnt_o
`endif
);
    import pcs_10g_pkg::*;

    // Handshake: a block transfers on a rising edge where head_v_i && ready_o;
    // when ready_o is low the presented block is left for the upstream to hold.
    // valid_o marks a new word on data_o for exactly that cycle.

    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic [63:0]       r_q, r_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              accept;
    logic [5:0]        shamt;
    logic [127:0]      cat;

    assign ready_o = (seq_q != GB_SEQ_MAX);
    assign accept  = head_v_i && ready_o;
    assign shamt   = {seq_q[4:0], 1'b0};

    // Residue bits above 2*seq are always zero, so an OR merges it under the block.
    assign cat = ({62'd0, data_i, sync_head_i} << shamt) | {64'd0, r_q};

    always_comb begin
        seq_d   = seq_q;
        r_d     = r_q;
        data_d  = data_q;
        valid_d = 1'b0;
        if (seq_q == GB_SEQ_MAX) begin
            data_d  = r_q;
            r_d     = '0;
            seq_d   = '0;
            valid_d = 1'b1;
        end else if (accept) begin
            data_d  = cat[63:0];
            r_d     = cat[127:64];
            seq_d   = seq_q + 6'd1;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seq_q   <= '0;
            r_q     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            seq_q   <= seq_d;
            r_q     <= r_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign seq_o   = seq_q;

`ifdef PCS_TX_GB_UNDERFLOW_CNT_EN
    logic        underflow;
    logic [15:0] uf_cnt_q, uf_cnt_d;

    always_comb begin
        underflow = !head_v_i && (seq_q != GB_SEQ_MAX);
        uf_cnt_d  = uf_cnt_q;
        if (underflow && (uf_cnt_q != 16'hFFFF)) begin
            uf_cnt_d = uf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            uf_cnt_q <= '0;
        end else begin
            uf_cnt_q <= uf_cnt_d;
        end
    end

    assign underflow_cnt_o = uf_cnt_q;
`endif

endmodule

// File: tb/tb_pcs_10g_tx_gearbox.sv
// Bench for pcs_10g_tx_gearbox: a bit-level stream model fills an expected word
// queue as blocks are accepted; a monitor pops and compares every valid word.
module tb_pcs_10g_tx_gearbox;
    import pcs_10g_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        head_v_i = 1'b0;
    logic [1:0]  sync_head_i = 2'b00;
    logic [63:0] data_i = 64'd0;
    logic        ready_o;
    logic        valid_o;
    logic [63:0] data_o;
    logic [5:0]  seq_o;
`ifdef PCS_TX_GB_UNDERFLOW_CNT_EN
    logic [15:0] underflow_cnt_o;
`endif

    pcs_10g_tx_gearbox dut (
        .clk            (clk),
        .reset          (reset),
        .head_v_i       (head_v_i),
        .sync_head_i    (sync_head_i),
        .data_i         (data_i),
        .ready_o        (ready_o),
        .valid_o        (valid_o),
        .data_o         (data_o),
        .seq_o          (seq_o)
`ifdef PCS_TX_GB_UNDERFLOW_CNT_EN
        ,
        .underflow_cnt_o(underflow_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass = 0;
    int          words_seen = 0;
    int          rdy_low_cnt = 0;
    bit          bq[$];
    logic [63:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Append one block to the serial stream, emitting every full 64-bit word.
    task automatic push_block(input logic [1:0] h, input logic [63:0] d);
        logic [63:0] w;
        for (int i = 0; i < 2; i++) bq.push_back(h[i]);
        for (int i = 0; i < 64; i++) bq.push_back(d[i]);
        while (bq.size() >= 64) begin
            for (int i = 0; i < 64; i++) w[i] = bq.pop_front();
            exp_q.push_back(w);
        end
    endtask

    task automatic drive(input logic hv, input logic [1:0] h, input logic [63:0] d,
                         output logic acc);
        @(negedge clk);
        head_v_i    = hv;
        sync_head_i = h;
        data_i      = d;
        acc = hv && ready_o && !reset;
        if (acc) push_block(h, d);
    endtask

    task automatic drive_idle();
        logic acc;
        drive(1'b0, 2'b00, 64'd0, acc);
    endtask

    task automatic send_block(input logic [1:0] h, input logic [63:0] d);
        logic acc;
        acc = 1'b0;
        for (int t = 0; t < 3 && !acc; t++) drive(1'b1, h, d, acc);
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_reset(input logic hv);
        @(negedge clk);
        reset       = 1'b1;
        head_v_i    = hv;
        sync_head_i = SYNC_HEAD_DATA;
        data_i      = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        reset    = 1'b0;
        head_v_i = 1'b0;
        chk("leftover_words", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        bq.delete();
        words_seen  = 0;
        rdy_low_cnt = 0;
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_data", data_o, 64'd0);
        chk("rst_seq", 64'(seq_o), 64'd0);
        chk("rst_ready", 64'(ready_o), 64'd1);
    endtask

    function automatic logic [1:0] rand_head();
        return ($urandom_range(0, 1) == 1) ? SYNC_HEAD_CTRL : SYNC_HEAD_DATA;
    endfunction

    always @(posedge clk) begin
        #1;
        if (valid_o) begin
            words_seen++;
            if (exp_q.size() == 0) chk("word_queue_empty", 64'd0, 64'd1);
            else chk("word", data_o, exp_q.pop_front());
        end
        if (!ready_o) begin
            rdy_low_cnt++;
            chk("seq_at_stall", 64'(seq_o), 64'd32);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] last_d;
        logic        acc;

        do_reset(1'b0);

        // Single all-ones data block.
        send_block(SYNC_HEAD_DATA, 64'hFFFF_FFFF_FFFF_FFFF);
        drive_idle();
        chk("s1_valid", 64'(valid_o), 64'd1);
        chk("s1_data", data_o, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("s1_seq", 64'(seq_o), 64'd1);

        // 32 back-to-back blocks, then a distinct block held across the stall.
        do_reset(1'b0);
        last_d = '0;
        for (int k = 0; k < 32; k++) begin
            last_d = {$urandom, $urandom};
            send_block(rand_head(), last_d);
        end
        drive(1'b1, SYNC_HEAD_CTRL, 64'hA5A5_5A5A_C3C3_3C3C, acc);
        chk("stall_accept", 64'(acc), 64'd0);
        chk("stall_ready", 64'(ready_o), 64'd0);
        chk("stall_seq", 64'(seq_o), 64'd32);
        drive(1'b1, SYNC_HEAD_CTRL, 64'hA5A5_5A5A_C3C3_3C3C, acc);
        chk("held_accept", 64'(acc), 64'd1);
        chk("drain_valid", 64'(valid_o), 64'd1);
        chk("drain_word", data_o, last_d);
        chk("drain_seq", 64'(seq_o), 64'd0);
        chk("drain_ready", 64'(ready_o), 64'd1);
        chk("words_33", 64'(words_seen), 64'd33);
        chk("ready_low_once", 64'(rdy_low_cnt), 64'd1);
        drive_idle();
        chk("held_seq", 64'(seq_o), 64'd1);

        // Three-cycle underflow gap at seq 10.
        do_reset(1'b0);
        for (int k = 0; k < 10; k++) send_block(rand_head(), {$urandom, $urandom});
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            if (i < 2) drive_idle();
            else send_block(rand_head(), {$urandom, $urandom});
            chk("gap_valid", 64'(valid_o), 64'd0);
            chk("gap_seq", 64'(seq_o), 64'd10);
        end
        for (int k = 0; k < 21; k++) send_block(rand_head(), {$urandom, $urandom});
        drive_idle();
        drive_idle();
        chk("gap_words_33", 64'(words_seen), 64'd33);
        chk("gap_seq_wrap", 64'(seq_o), 64'd0);

        // Reset at seq 20 with a block presented during reset.
        do_reset(1'b0);
        for (int k = 0; k < 20; k++) send_block(rand_head(), {$urandom, $urandom});
        do_reset(1'b1);
        send_block(SYNC_HEAD_DATA, 64'hFFFF_FFFF_FFFF_FFFF);
        drive_idle();
        chk("s5_data", data_o, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("s5_seq", 64'(seq_o), 64'd1);

`ifdef PCS_TX_GB_UNDERFLOW_CNT_EN
        do_reset(1'b0);
        repeat (4) drive_idle();
        @(negedge clk);
        chk("uf_cnt_5", 64'(underflow_cnt_o), 64'd5);
        repeat (70000) @(negedge clk);
        chk("uf_cnt_sat", 64'(underflow_cnt_o), 64'hFFFF);
`endif

        drive_idle();
        drive_idle();
        chk("end_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
